// File: rtl/timing_pkg.sv
// Shared types and constants for the LVDT excitation-timing blocks.
package timing_pkg;

  // Controller state, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    DELAY  = 2'd2,
    STROBE = 2'd3
  } state_e;

  // Default width of the win_len / strobe_dly count fields.
  localparam int CW_DEFAULT = 8;

  // A two-flop synchroniser is the shallowest chain considered metastability-safe.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser followed by a rising-edge detector.
// After reset the detector stays quiet until the delay flop holds a real
// sample of d_i, so an input that is already high at reset release is not
// mistaken for a rising edge.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic [STAGES:0]   fill_q;

  // Synchroniser chain, edge-delay flop and post-reset fill tracker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
      fill_q <= {fill_q[STAGES-1:0], 1'b1};
    end
  end

  // fill_q[STAGES] marks that dly_q now carries a genuine sampled value.
  assign rise_o = sync_q[STAGES-1] & ~dly_q & fill_q[STAGES];

endmodule

// File: rtl/timing_ctrl_prog.sv
// Programmable excitation-timing controller: each carry rising edge opens a
// measurement window (out2); after a programmable delay a strobe of PULSE_W
// cycles follows. Supports retrigger, enable gating and an overrun counter.
module timing_ctrl_prog
  import timing_pkg::*;
#(
  parameter int CW          = CW_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN,
  parameter int PULSE_W     = 1,
  parameter int OVR_W       = 8
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             carry,
  input  logic             retrig_mode,
  input  logic [CW-1:0]    win_len,
  input  logic [CW-1:0]    strobe_dly,
  input  logic             ovr_clr,
  output logic             out2,
  output logic             strobe,
  output logic             busy,
  output logic [OVR_W-1:0] ovr_cnt
);

  // Depth and width are clamped to the legal range rather than trusted.
  localparam int SYNC_D = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int PULSE_D = (PULSE_W < 1) ? 1 : ((PULSE_W > 15) ? 15 : PULSE_W);
  // One shared down-counter serves window, delay and strobe phases.
  localparam int CNT_W = (CW > 4) ? CW : 4;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_D);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    dly_sh_q;
  logic             retrig_sh_q;
  logic             load_cfg;
  logic             ovr_inc;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic             out2_q, out2_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             trig;
  logic [CNT_W-1:0] win_ld;

  sync_edge_det #(
    .STAGES (SYNC_D)
  ) u_sync (
    .clk_i  (mclk),
    .rst_ni (rst),
    .d_i    (carry),
    .rise_o (trig)
  );

  // A zero window length still produces a one-cycle window.
  assign win_ld = (win_len == '0) ? CNT_ONE : CNT_W'(win_len);

  // State register.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state, counter load and overrun decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_cfg = 1'b0;
    ovr_inc  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_d  = WINDOW;
            cnt_d    = win_ld;
            load_cfg = 1'b1;
          end
        end
        WINDOW: begin
          if (trig && retrig_sh_q) begin
            cnt_d    = win_ld;
            load_cfg = 1'b1;
          end else begin
            ovr_inc = trig;
            if (cnt_q == CNT_ONE) begin
              if (dly_sh_q == '0) begin
                state_d = STROBE;
                cnt_d   = PULSE_LD;
              end else begin
                state_d = DELAY;
                cnt_d   = CNT_W'(dly_sh_q);
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        DELAY: begin
          ovr_inc = trig;
          if (cnt_q == CNT_ONE) begin
            state_d = STROBE;
            cnt_d   = PULSE_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        STROBE: begin
          ovr_inc = trig;
          if (cnt_q == CNT_ONE) state_d = IDLE;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating overrun counter; a clear coinciding with a drop leaves one.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_clr)                 ovr_d = ovr_inc ? OVR_W'(1) : '0;
    else if (ovr_inc && !(&ovr_q)) ovr_d = ovr_q + OVR_W'(1);
  end

  // Output decode; enable gates the outputs so they drop with the state.
  always_comb begin
    out2_d   = enable && (state_q == WINDOW);
    strobe_d = enable && (state_q == STROBE);
    busy_d   = enable && (state_q != IDLE);
  end

  // Phase counter, shadow configuration and overrun count.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      dly_sh_q    <= '0;
      retrig_sh_q <= 1'b0;
      ovr_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      if (load_cfg) begin
        dly_sh_q    <= strobe_dly;
        retrig_sh_q <= retrig_mode;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      out2_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      out2_q   <= out2_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign out2    = out2_q;
  assign strobe  = strobe_q;
  assign busy    = busy_q;
  assign ovr_cnt = ovr_q;

endmodule

// File: doc/timing_ctrl_prog.md
Name: timing_ctrl_prog

Overview:
- Parametrised, runtime-programmable successor to the fixed excitation-timing controller in the LVDT signal chain.
- Each rising edge of the excitation-phase carry opens a measurement window (out2) of programmable length.
- After a programmable delay from the window end, the block emits a strobe pulse of parameterised width for the sampling/latch stage.
- Adds retrigger mode, enable gating, an overrun counter and a busy flag; fully synchronous to mclk, with no inverted-clock stages.

Parameters:
- CW, 8, width of the win_len and strobe_dly count fields.
- SYNC_STAGES, 2, synchroniser depth on carry (minimum 2).
- PULSE_W, 1, strobe width in mclk cycles (1..15).
- OVR_W, 8, overrun counter width.

Ports:
- mclk  in  1  system clock, rising edge only.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- enable  in  1  block enable; when 0, forces IDLE and ignores triggers.
- carry  in  1  asynchronous excitation carry; its rising edge is the trigger.
- retrig_mode  in  1  1 = a trigger during the window restarts it; 0 = that trigger counts as an overrun.
- win_len  in  CW  window length in cycles; 0 is treated as 1.
- strobe_dly  in  CW  cycles from window end to strobe start; 0 means the strobe follows immediately.
- ovr_clr  in  1  synchronous clear of ovr_cnt.
- out2  out  1  measurement window, registered.
- strobe  out  1  sampling strobe, registered.
- busy  out  1  high whenever state is not IDLE.
- ovr_cnt  out  OVR_W  saturating count of dropped triggers.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, synchroniser and edge registers=0, counters=0. out2=0, strobe=0, busy=0, ovr_cnt=0.
- Trigger detection: carry passes through SYNC_STAGES flops, then one delay flop. trig = sync_out & ~delayed.
- Trigger latency: carry first sampled high at edge k gives out2=1 after edge k+SYNC_STAGES+1. With the default this is 3 cycles.
- Configuration: win_len, strobe_dly and retrig_mode are captured into shadow registers when a trigger is accepted. Changes mid-operation take effect at the next accepted trigger.
- IDLE: on trig with enable=1, go to WINDOW and load win_cnt=max(win_len,1).
- WINDOW: out2=1; win_cnt decrements each cycle. When win_cnt reaches 1: if shadow dly=0 go to STROBE, else go to DELAY and load dly_cnt=dly. out2 is high for exactly max(win_len,1) cycles.
- DELAY: outputs low; dly_cnt decrements; at 1, go to STROBE.
- STROBE: strobe=1 for PULSE_W cycles, then go to IDLE. busy falls in the same cycle that strobe falls.
- Trigger while in WINDOW:
  - retrig_mode=1: reload win_cnt from the live win_len and stay in WINDOW; out2 stays high with no glitch.
  - retrig_mode=0: ignore the trigger and increment ovr_cnt.
- Trigger while in DELAY or STROBE: ignore it and increment ovr_cnt.
- Trigger in the same cycle as the return to IDLE: the trigger is dropped and counted. No back-to-back acceptance.
- ovr_cnt saturates at 2^OVR_W-1. If ovr_clr and an increment coincide, the next value is 1.
- enable=0 in any state: go to IDLE on the next edge and drive out2/strobe low next cycle. Triggers are ignored and not counted. The synchroniser keeps running, so an edge that occurs while disabled is not replayed.
- rst asserted mid-operation: outputs clear immediately and asynchronously. After release, a carry that is already high produces no trigger because a rising edge is required.

Decomposition:
- Shared package timing_pkg holds:
  - the state enum {IDLE, WINDOW, DELAY, STROBE} as a 2-bit encoding;
  - the CW default constant;
  - the SYNC_STAGES minimum constant.
- One sub-module, sync_edge_det: a parametrised-depth synchroniser plus rising-edge detector, also reused by other LVDT blocks.
- Counters and FSM stay in the top module.

Test Plan:
- Basic: win_len=9, strobe_dly=0, pulse on carry at edge 10 → out2 high for edges 13..21 (9 cycles), strobe for 1 cycle at edge 22, busy spans 13..22, ovr_cnt=0.
- Delay and width: win_len=4, strobe_dly=3, PULSE_W=2 → out2 high 4 cycles, 3 low cycles, strobe high 2 cycles, then IDLE. Check that win_len=0 gives a 1-cycle out2.
- Retrigger: retrig_mode=1, win_len=8, second carry edge detected at window cycle 5 → out2 continuous for 5+8=13 cycles, ovr_cnt=0. Repeat with retrig_mode=0 → out2 8 cycles, ovr_cnt=1.
- Overrun saturation: OVR_W=2, inject 5 triggers during DELAY → ovr_cnt=3. Assert ovr_clr coincident with a 6th trigger → ovr_cnt=1.
- Enable/reset mid-op: drop enable during WINDOW → out2=0 next cycle, busy=0, a carry edge while disabled is neither counted nor replayed. Pull rst low during STROBE → all outputs 0 asynchronously. Release with carry held high → no trigger.
- Config shadowing: change win_len from 6 to 2 during WINDOW with retrig_mode=0 → current window stays 6 cycles, next trigger gives 2 cycles.
